// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO for the I2S sample path (TX/RX buffering).
// It keeps an occupancy count with full, empty, almost-full and almost-empty
// decodes, supports a synchronous flush, and has sticky overflow/underflow flags.
// dataOut is registered, so a read word appears one cycle after the read is accepted.
module fifo_sync_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       FLUSH,
  input  logic                       WR,
  input  logic [DATA_W-1:0]          dataIn,
  input  logic                       RD,
  output logic [DATA_W-1:0]          dataOut,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       AEMPTY,
  output logic                       AFULL,
  input  logic                       CLR_ERR,
  output logic                       OVF,
  output logic                       UDF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // The storage array is never reset, so it maps onto plain RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic          rd_ok;
  logic          wr_ok;
  logic          wr_rej;
  logic          rd_rej;
  logic [CW-1:0] count_nxt;

  // Decide which requests are accepted, using the Count registered at the start of the cycle.
  // When the FIFO is full, a simultaneous read frees a slot, so the write is also accepted.
  always_comb begin
    rd_ok     = RD & (Count != '0);
    wr_ok     = WR & ((Count != DEPTH_C) | rd_ok);
    wr_rej    = WR & ~wr_ok;
    rd_rej    = RD & ~rd_ok;
    count_nxt = Count + CW'(wr_ok) - CW'(rd_ok);
  end

  // Decode the status flags directly from the registered Count.
  always_comb begin
    EMPTY  = (Count == '0);
    FULL   = (Count == DEPTH_C);
    AEMPTY = (Count <= AE_C);
    AFULL  = (Count >= AF_C);
  end

  // Write into the storage array. The write is blocked during reset, while disabled, and on flush.
  always_ff @(posedge clk) begin
    if (Rst && EN && !FLUSH && wr_ok) begin
      mem[wptr] <= dataIn;
    end
  end

  // Update pointers, Count, read data and the sticky error flags.
  // Priority is reset, then enable, then flush, then normal operation.
  // When the same entry is read and written in one cycle, the read returns the old word.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      wptr    <= '0;
      rptr    <= '0;
      Count   <= '0;
      dataOut <= '0;
      OVF     <= 1'b0;
      UDF     <= 1'b0;
    end else if (EN) begin
      if (FLUSH) begin
        wptr  <= '0;
        rptr  <= '0;
        Count <= '0;
      end else begin
        if (wr_ok) begin
          wptr <= wptr + 1'b1;
        end
        if (rd_ok) begin
          rptr    <= rptr + 1'b1;
          dataOut <= mem[rptr];
        end
        Count <= count_nxt;
        // A new error wins over a clear issued in the same cycle.
        OVF   <= (OVF & ~CLR_ERR) | wr_rej;
        UDF   <= (UDF & ~CLR_ERR) | rd_rej;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed testbench for fifo_sync_param with DEPTH=8, AF_LEVEL=6 and AE_LEVEL=2.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        EN = 1'b1;
  logic        FLUSH = 1'b0;
  logic        WR = 1'b0;
  logic [31:0] dataIn = '0;
  logic        RD = 1'b0;
  logic [31:0] dataOut;
  logic [3:0]  Count;
  logic        EMPTY, FULL, AEMPTY, AFULL;
  logic        CLR_ERR = 1'b0;
  logic        OVF, UDF;

  int n_cmp = 0;
  int n_fail = 0;

  fifo_sync_param #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .Rst(Rst), .EN(EN), .FLUSH(FLUSH), .WR(WR), .dataIn(dataIn),
    .RD(RD), .dataOut(dataOut), .Count(Count), .EMPTY(EMPTY), .FULL(FULL),
    .AEMPTY(AEMPTY), .AFULL(AFULL), .CLR_ERR(CLR_ERR), .OVF(OVF), .UDF(UDF)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then return #1 after the edge with the requests deasserted.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    WR = w; RD = r; dataIn = d;
    @(posedge clk); #1;
    WR = 1'b0; RD = 1'b0; CLR_ERR = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    Rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    n_cmp++; if (Count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", Count); end
    n_cmp++; if ({EMPTY, AEMPTY, FULL, AFULL} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got=%b exp=1100", {EMPTY, AEMPTY, FULL, AFULL}); end
    n_cmp++; if ({OVF, UDF} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {OVF, UDF}); end
    n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dataOut); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 32'hA0 + i);
      n_cmp++; if (Count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, Count, i + 1); end
      n_cmp++; if (AFULL !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, AFULL, (i + 1 >= 6)); end
      n_cmp++; if (FULL !== (i == 7)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, FULL, (i == 7)); end
      n_cmp++; if (AEMPTY !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, AEMPTY, (i + 1 <= 2)); end
    end
    cyc(1'b1, 1'b0, 32'hBAD);
    n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", OVF); end
    n_cmp++; if (Count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got=%0d exp=8", Count); end
    n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL dout_before_read got=%h exp=0", dataOut); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      n_cmp++; if (dataOut !== 32'hA0 + i) begin n_fail++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dataOut, 32'hA0 + i); end
    end
    n_cmp++; if ({EMPTY, Count} !== 5'b1_0000) begin n_fail++; $display("FAIL drain_empty got=%b exp=10000", {EMPTY, Count}); end
    CLR_ERR = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", OVF); end
  endtask

  task automatic test_wrap();
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h100 + rep * 5 + i);
      n_cmp++; if (Count !== 4'd5) begin n_fail++; $display("FAIL wrap_count[%0d] got=%0d exp=5", rep, Count); end
      for (int i = 0; i < 5; i++) begin
        cyc(1'b0, 1'b1, 32'h0);
        n_cmp++; if (dataOut !== 32'h100 + rep * 5 + i) begin n_fail++; $display("FAIL wrap_dout[%0d.%0d] got=%h exp=%h", rep, i, dataOut, 32'h100 + rep * 5 + i); end
      end
    end
    n_cmp++; if ({OVF, UDF, EMPTY} !== 3'b001) begin n_fail++; $display("FAIL wrap_flags got=%b exp=001", {OVF, UDF, EMPTY}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'hC0 + i);
    cyc(1'b1, 1'b1, 32'h55);
    n_cmp++; if (Count !== 4'd8) begin n_fail++; $display("FAIL full_rw_count got=%0d exp=8", Count); end
    n_cmp++; if (dataOut !== 32'hC0) begin n_fail++; $display("FAIL full_rw_dout got=%h exp=c0", dataOut); end
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf got=%b exp=0", OVF); end
    for (int i = 1; i < 9; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      n_cmp++; if (dataOut !== ((i == 8) ? 32'h55 : 32'hC0 + i)) begin n_fail++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, dataOut, (i == 8) ? 32'h55 : 32'hC0 + i); end
    end
    cyc(1'b1, 1'b1, 32'h66);
    n_cmp++; if (Count !== 4'd1) begin n_fail++; $display("FAIL empty_rw_count got=%0d exp=1", Count); end
    n_cmp++; if (UDF !== 1'b1) begin n_fail++; $display("FAIL empty_rw_udf got=%b exp=1", UDF); end
    n_cmp++; if (dataOut !== 32'h55) begin n_fail++; $display("FAIL empty_rw_dout got=%h exp=55", dataOut); end
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (dataOut !== 32'h66) begin n_fail++; $display("FAIL empty_rw_read got=%h exp=66", dataOut); end
    CLR_ERR = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    n_cmp++; if (UDF !== 1'b0) begin n_fail++; $display("FAIL udf_clear got=%b exp=0", UDF); end
  endtask

  task automatic test_flush_enable();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hD0 + i);
    n_cmp++; if (Count !== 4'd4) begin n_fail++; $display("FAIL pre_flush_count got=%0d exp=4", Count); end
    FLUSH = 1'b1;
    cyc(1'b1, 1'b0, 32'hDD);
    n_cmp++; if ({EMPTY, Count} !== 5'b1_0000) begin n_fail++; $display("FAIL flush_empty got=%b exp=10000", {EMPTY, Count}); end
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got=%b exp=0", OVF); end
    n_cmp++; if (dataOut !== 32'h66) begin n_fail++; $display("FAIL flush_dout_hold got=%h exp=66", dataOut); end
    cyc(1'b1, 1'b0, 32'hE0);
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (dataOut !== 32'hE0) begin n_fail++; $display("FAIL post_flush_read got=%h exp=e0", dataOut); end
    cyc(1'b1, 1'b0, 32'hE1);
    cyc(1'b1, 1'b0, 32'hE2);
    EN = 1'b0;
    cyc(1'b1, 1'b1, 32'hEE);
    cyc(1'b0, 1'b1, 32'h0);
    EN = 1'b1;
    n_cmp++; if (Count !== 4'd2) begin n_fail++; $display("FAIL en0_count got=%0d exp=2", Count); end
    n_cmp++; if (dataOut !== 32'hE0) begin n_fail++; $display("FAIL en0_dout got=%h exp=e0", dataOut); end
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (dataOut !== 32'hE1) begin n_fail++; $display("FAIL en0_read1 got=%h exp=e1", dataOut); end
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (dataOut !== 32'hE2) begin n_fail++; $display("FAIL en0_read2 got=%h exp=e2", dataOut); end
    EN = 1'b0;
    cyc(1'b0, 1'b1, 32'h0);
    EN = 1'b1;
    n_cmp++; if (UDF !== 1'b0) begin n_fail++; $display("FAIL en0_no_udf got=%b exp=0", UDF); end
  endtask

  task automatic test_errors();
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (UDF !== 1'b1) begin n_fail++; $display("FAIL udf_set got=%b exp=1", UDF); end
    CLR_ERR = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    n_cmp++; if (UDF !== 1'b0) begin n_fail++; $display("FAIL udf_clr got=%b exp=0", UDF); end
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 32'hF0 + i);
    n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set2 got=%b exp=1", OVF); end
    CLR_ERR = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2 got=%b exp=0", OVF); end
    CLR_ERR = 1'b1;
    cyc(1'b1, 1'b0, 32'hF9);
    n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set got=%b exp=1", OVF); end
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);
    Rst = 1'b0;
    cyc(1'b1, 1'b1, 32'h77);
    Rst = 1'b1;
    n_cmp++; if (Count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", Count); end
    n_cmp++; if ({EMPTY, AEMPTY, FULL, AFULL, OVF, UDF} !== 6'b110000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=110000", {EMPTY, AEMPTY, FULL, AFULL, OVF, UDF}); end
    n_cmp++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL midrst_dout got=%h exp=0", dataOut); end
    cyc(1'b1, 1'b0, 32'h11);
    cyc(1'b0, 1'b1, 32'h0);
    n_cmp++; if (dataOut !== 32'h11) begin n_fail++; $display("FAIL midrst_after got=%h exp=11", dataOut); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_flush_enable();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
